// File: rtl/top_core.sv
// top_core: registered 4-bit two-operand logic/arithmetic unit.
// The result, carry/borrow, zero flag and valid are registered one cycle
// after an accepted input. Inputs are accepted when in_valid is high.
// Optional build macro: TOP_SAT_EN. When defined, ADD saturates to 4'hF on
// overflow and SUB clamps to 4'h0 on borrow. The carry output still reports
// the overflow or borrow in both builds.
module top_core (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [2:0] op,
  input  logic [3:0] top1,
  input  logic [3:0] top2,
  output logic [3:0] top_res,
  output logic       out_valid,
  output logic       carry,
  output logic       zero
);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_ADD  = 3'b011,
    OP_SUB  = 3'b100,
    OP_NOT  = 3'b101,
    OP_PASS = 3'b110,
    OP_NAND = 3'b111
  } op_e;

  op_e        op_sel;
  logic [4:0] sum;
  logic [4:0] diff;
  logic [3:0] res_d;
  logic       carry_d;
  logic [3:0] res_q;
  logic       carry_q;
  logic       zero_q;
  logic       valid_q;

  assign op_sel = op_e'(op);

  // Combinational result and carry/borrow for the current operands.
  // diff[4] is the borrow, because the 5-bit unsigned subtract wraps.
  always_comb begin
    sum     = {1'b0, top1} + {1'b0, top2};
    diff    = {1'b0, top1} - {1'b0, top2};
    res_d   = '0;
    carry_d = 1'b0;
    case (op_sel)
      OP_AND:  res_d = top1 & top2;
      OP_OR:   res_d = top1 | top2;
      OP_XOR:  res_d = top1 ^ top2;
      OP_ADD: begin
        carry_d = sum[4];
`ifdef TOP_SAT_EN
        res_d   = sum[4] ? '1 : sum[3:0];
`else
        res_d   = sum[3:0];
`endif
      end
      OP_SUB: begin
        carry_d = diff[4];
`ifdef TOP_SAT_EN
        res_d   = diff[4] ? '0 : diff[3:0];
`else
        res_d   = diff[3:0];
`endif
      end
      OP_NOT:  res_d = ~top1;
      OP_PASS: res_d = top1;
      OP_NAND: res_d = ~(top1 & top2);
    endcase
  end

  // Output registers. Reset has priority over in_valid.
  // Result and flags hold their values while in_valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        res_q   <= res_d;
        carry_q <= carry_d;
        zero_q  <= (res_d == '0);
      end
    end
  end

  assign top_res   = res_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_top_core.sv
// Directed self-checking bench for top_core.
// Expected values are computed by hand, with separate values for the
// TOP_SAT_EN build where saturation changes the result.
module tb_top_core;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [2:0] op;
  logic [3:0] top1;
  logic [3:0] top2;
  logic [3:0] top_res;
  logic       out_valid;
  logic       carry;
  logic       zero;

  int unsigned n_checks;
  int unsigned n_fail;

  top_core dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .op        (op),
    .top1      (top1),
    .top2      (top2),
    .top_res   (top_res),
    .out_valid (out_valid),
    .carry     (carry),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef TOP_SAT_EN
  localparam logic [3:0] ADD_OVF_RES  = 4'hF;
  localparam logic       ADD_OVF_Z    = 1'b0;
  localparam logic [3:0] ADD_OVF2_RES = 4'hF;
  localparam logic [3:0] SUB_BRW_RES  = 4'h0;
  localparam logic       SUB_BRW_Z    = 1'b1;
`else
  localparam logic [3:0] ADD_OVF_RES  = 4'h0;
  localparam logic       ADD_OVF_Z    = 1'b1;
  localparam logic [3:0] ADD_OVF2_RES = 4'h1;
  localparam logic [3:0] SUB_BRW_RES  = 4'hE;
  localparam logic       SUB_BRW_Z    = 1'b0;
`endif

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs on the falling edge.
  // The outputs are sampled 1 time unit after the next rising edge.
  task automatic step(input logic r, input logic v, input logic [2:0] o,
                      input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    op       = o;
    top1     = a;
    top2     = b;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] res, input logic v,
                            input logic c, input logic z);
    check({tag, ".res"},   top_res,   res);
    check({tag, ".valid"}, {3'b0, out_valid}, {3'b0, v});
    check({tag, ".carry"}, {3'b0, carry},     {3'b0, c});
    check({tag, ".zero"},  {3'b0, zero},      {3'b0, z});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; in_valid = 1'b0; op = 3'b000; top1 = '0; top2 = '0;

    // Hold reset for two cycles.
    step(1'b1, 1'b0, 3'b000, 4'h0, 4'h0);
    step(1'b1, 1'b0, 3'b000, 4'h0, 4'h0);
    expect_out("reset", 4'h0, 1'b0, 1'b0, 1'b1);

    // Three back-to-back AND operations.
    step(1'b0, 1'b1, 3'b000, 4'b1010, 4'b1111);
    expect_out("and0", 4'b1010, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 3'b000, 4'b0101, 4'b1111);
    expect_out("and1", 4'b0101, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 3'b000, 4'b1111, 4'b1111);
    expect_out("and2", 4'b1111, 1'b1, 1'b0, 1'b0);

    // ADD that overflows.
    step(1'b0, 1'b1, 3'b011, 4'b1111, 4'b0001);
    expect_out("add_ovf", ADD_OVF_RES, 1'b1, 1'b1, ADD_OVF_Z);

    // ADD with no carry.
    step(1'b0, 1'b1, 3'b011, 4'b0011, 4'b0100);
    expect_out("add", 4'b0111, 1'b1, 1'b0, 1'b0);

    // SUB with a borrow.
    step(1'b0, 1'b1, 3'b100, 4'b0011, 4'b0101);
    expect_out("sub_brw", SUB_BRW_RES, 1'b1, 1'b1, SUB_BRW_Z);

    // SUB with no borrow, then SUB of equal operands.
    step(1'b0, 1'b1, 3'b100, 4'b0111, 4'b0010);
    expect_out("sub", 4'b0101, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 3'b100, 4'b0101, 4'b0101);
    expect_out("sub_eq", 4'b0000, 1'b1, 1'b0, 1'b1);

    // Remaining logic ops.
    step(1'b0, 1'b1, 3'b001, 4'b1100, 4'b0011);
    expect_out("or", 4'b1111, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 3'b101, 4'b1010, 4'b0000);
    expect_out("not", 4'b0101, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 3'b110, 4'b0110, 4'b1001);
    expect_out("pass", 4'b0110, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 3'b111, 4'b1100, 4'b1010);
    expect_out("nand", 4'b0111, 1'b1, 1'b0, 1'b0);

    // XOR, then an idle cycle. The result holds and out_valid drops.
    step(1'b0, 1'b1, 3'b010, 4'b1010, 4'b1111);
    expect_out("xor", 4'b0101, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 3'b000, 4'b0000, 4'b0000);
    expect_out("xor_hold", 4'b0101, 1'b0, 1'b0, 1'b0);

    // ADD with a carry, then idle cycles. The carry also holds.
    step(1'b0, 1'b1, 3'b011, 4'b1001, 4'b1000);
    expect_out("add_c", ADD_OVF2_RES, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 3'b111, 4'b0000, 4'b0000);
    expect_out("add_c_hold", ADD_OVF2_RES, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 3'b000, 4'b0000, 4'b0000);
    expect_out("add_c_hold2", ADD_OVF2_RES, 1'b0, 1'b1, 1'b0);

    // Valid input followed by reset with in_valid still high.
    // Reset wins over in_valid.
    step(1'b0, 1'b1, 3'b011, 4'b1111, 4'b0001);
    expect_out("pre_rst", ADD_OVF_RES, 1'b1, 1'b1, ADD_OVF_Z);
    step(1'b1, 1'b1, 3'b000, 4'b1111, 4'b1111);
    expect_out("mid_rst", 4'h0, 1'b0, 1'b0, 1'b1);

    // Recovery after reset.
    step(1'b0, 1'b1, 3'b010, 4'b0011, 4'b0101);
    expect_out("post_rst", 4'b0110, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
